// File: rtl/data_mem_responder.sv
// Data-memory bus responder: serialized load/store slave with configurable wait states,
// byte/half/word lanes, load extension, and misalignment/range error reporting.
//
// state  | meaning
// IDLE   | waiting for busReq; captures the request on the accepting edge
// WAIT   | request held in capture registers, counting down wait states
// RESP   | busReady high for one cycle, memory access already committed
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic [2:0]  busFunc3,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_func3;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      off;
    logic [IDX_W-1:0] word_idx;
    logic             is_half;
    logic             is_word;
    logic             func_err;
    logic             req_err;
    logic             enter_resp;
    logic [31:0]      rd_word;
    logic [31:0]      rd_lane;
    logic [31:0]      load_data;
    logic [31:0]      wr_data;
    logic [3:0]       wr_be;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fail the range test.
    assign off      = cap_addr - BASE_ADDR;
    assign word_idx = off[IDX_W+1:2];
    assign is_half  = (cap_func3[1:0] == 2'b01);
    assign is_word  = (cap_func3[1:0] == 2'b10);
    assign func_err = (cap_func3 == 3'b011) || (cap_func3[2:1] == 2'b11);

    assign req_err = (off >= SPAN_BYTES)
                   | (is_half & cap_addr[0])
                   | (is_word & (|cap_addr[1:0]))
                   | func_err
                   | (cap_we & cap_func3[2]);

    assign enter_resp = (state == ST_WAIT) && (wait_cnt == 4'd0);

    assign rd_word = mem[word_idx];
    assign rd_lane = rd_word >> {cap_addr[1:0], 3'b000};

    always_comb begin
        load_data = rd_word;
        case (cap_func3)
            3'b000:  load_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
            3'b001:  load_data = {{16{rd_lane[15]}}, rd_lane[15:0]};
            3'b100:  load_data = {24'd0, rd_lane[7:0]};
            3'b101:  load_data = {16'd0, rd_lane[15:0]};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        wr_data = cap_wdata;
        wr_be   = 4'b1111;
        case (cap_func3[1:0])
            2'b00: begin
                wr_data = {4{cap_wdata[7:0]}};
                wr_be   = 4'b0001 << cap_addr[1:0];
            end
            2'b01: begin
                wr_data = {2{cap_wdata[15:0]}};
                wr_be   = cap_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = cap_wdata;
                wr_be   = 4'b1111;
            end
        endcase
    end

    // The accepting edge only captures; decode happens from the capture registers, so
    // WAIT always spends at least one cycle and the counter is loaded with WAIT_STATES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_func3 <= 3'd0;
            busReady  <= 1'b0;
            busErr    <= 1'b0;
            busRData  <= 32'd0;
        end else begin
            busReady <= 1'b0;
            busErr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (busReq) begin
                        cap_we    <= busWe;
                        cap_addr  <= busAddr;
                        cap_wdata <= busWData;
                        cap_func3 <= busFunc3;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= ST_RESP;
                        busReady <= 1'b1;
                        busErr   <= req_err;
                        busRData <= (req_err || cap_we) ? 32'd0 : load_data;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cap_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with WAIT_STATES 0, 1 and 3.
module tb_data_mem_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [2:0]  F_B  = 3'b000;
    localparam logic [2:0]  F_H  = 3'b001;
    localparam logic [2:0]  F_W  = 3'b010;
    localparam logic [2:0]  F_BU = 3'b100;
    localparam logic [2:0]  F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst    [3];
    logic        req    [3];
    logic        we     [3];
    logic [31:0] addr_v [3];
    logic [31:0] wdata  [3];
    logic [2:0]  f3     [3];
    logic [31:0] rdata  [3];
    logic        ready  [3];
    logic        err    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst[0]), .busReq(req[0]), .busWe(we[0]), .busAddr(addr_v[0]),
        .busWData(wdata[0]), .busFunc3(f3[0]), .busRData(rdata[0]), .busReady(ready[0]),
        .busErr(err[0]));

    data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst[1]), .busReq(req[1]), .busWe(we[1]), .busAddr(addr_v[1]),
        .busWData(wdata[1]), .busFunc3(f3[1]), .busRData(rdata[1]), .busReady(ready[1]),
        .busErr(err[1]));

    data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst[2]), .busReq(req[2]), .busWe(we[2]), .busAddr(addr_v[2]),
        .busWData(wdata[2]), .busFunc3(f3[2]), .busRData(rdata[2]), .busReady(ready[2]),
        .busErr(err[2]));

    // Issues one request and returns the response plus the edge count from capture to busReady.
    task automatic do_req(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, output logic [31:0] rd, output logic e,
                          output int lat);
        logic seen;
        seen = 1'b0;
        rd   = 32'd0;
        e    = 1'b0;
        lat  = 0;
        @(negedge clk);
        we[u] = w; addr_v[u] = a; wdata[u] = d; f3[u] = f; req[u] = 1'b1;
        @(posedge clk); #1;
        req[u] = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ready[u]) begin
                seen = 1'b1;
                rd   = rdata[u];
                e    = err[u];
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL req_timeout unit=%0d addr=%h got no busReady within 40 edges", u, a);
            lat = -1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            checks += 3;
            if (ready[u] !== 1'b0) begin errors++; $display("FAIL reset_ready unit=%0d got %b exp 0", u, ready[u]); end
            if (err[u] !== 1'b0) begin errors++; $display("FAIL reset_err unit=%0d got %b exp 0", u, err[u]); end
            if (rdata[u] !== 32'd0) begin errors++; $display("FAIL reset_rdata unit=%0d got %h exp 0", u, rdata[u]); end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e; int lat;
        do_req(1, 1'b1, BASE, 32'hDEAD_BEEF, F_W, rd, e, lat);
        checks += 3;
        if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
        if (e !== 1'b0) begin errors++; $display("FAIL sw_err got %b exp 0", e); end
        if (rd !== 32'd0) begin errors++; $display("FAIL sw_rdata got %h exp 0", rd); end
        do_req(1, 1'b0, BASE, 32'd0, F_W, rd, e, lat);
        checks += 2;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_after_sw got %h exp deadbeef", rd); end
        if (e !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", e); end
        checks += 2;
        if (rdata[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdata_hold got %h exp deadbeef", rdata[1]); end
        if (ready[1] !== 1'b0) begin errors++; $display("FAIL ready_one_cycle got %b exp 0", ready[1]); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic e; int lat;
        do_req(1, 1'b1, BASE + 32'd3, 32'h0000_0080, F_B, rd, e, lat);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL sb_err got %b exp 0", e); end
        do_req(1, 1'b0, BASE, 32'd0, F_W, rd, e, lat);
        checks++;
        if (rd !== 32'h80AD_BEEF) begin errors++; $display("FAIL lw_after_sb got %h exp 80adbeef", rd); end
        do_req(1, 1'b0, BASE + 32'd3, 32'd0, F_B, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_3 got %h exp ffffff80", rd); end
        do_req(1, 1'b0, BASE + 32'd3, 32'd0, F_BU, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_3 got %h exp 00000080", rd); end
        do_req(1, 1'b0, BASE + 32'd2, 32'd0, F_H, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF_80AD) begin errors++; $display("FAIL lh_2 got %h exp ffff80ad", rd); end
        do_req(1, 1'b0, BASE + 32'd2, 32'd0, F_HU, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_80AD) begin errors++; $display("FAIL lhu_2 got %h exp 000080ad", rd); end
        do_req(1, 1'b0, BASE, 32'd0, F_H, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_0 got %h exp ffffbeef", rd); end
        do_req(1, 1'b0, BASE + 32'd1, 32'd0, F_BU, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_00BE) begin errors++; $display("FAIL lbu_1 got %h exp 000000be", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        do_req(1, 1'b1, BASE + 32'd1, 32'h0000_FFFF, F_H, rd, e, lat);
        checks += 2;
        if (e !== 1'b1) begin errors++; $display("FAIL sh_misaligned_err got %b exp 1", e); end
        if (rd !== 32'd0) begin errors++; $display("FAIL sh_misaligned_rdata got %h exp 0", rd); end
        checks++;
        if (err[1] !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err[1]); end
        do_req(1, 1'b0, BASE, 32'd0, F_W, rd, e, lat);
        checks++;
        if (rd !== 32'h80AD_BEEF) begin errors++; $display("FAIL word_unchanged got %h exp 80adbeef", rd); end
        do_req(1, 1'b0, BASE + 32'd1024, 32'd0, F_W, rd, e, lat);
        checks += 2;
        if (e !== 1'b1) begin errors++; $display("FAIL lw_past_end_err got %b exp 1", e); end
        if (rd !== 32'd0) begin errors++; $display("FAIL lw_past_end_rdata got %h exp 0", rd); end
        do_req(1, 1'b0, 32'h0FFF_FFFC, 32'd0, F_W, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL lw_below_base_err got %b exp 1", e); end
        do_req(1, 1'b0, BASE + 32'd1020, 32'd0, F_W, rd, e, lat);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL lw_last_word_err got %b exp 0", e); end
        do_req(1, 1'b0, BASE + 32'd2, 32'd0, F_W, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL lw_misaligned_err got %b exp 1", e); end
        do_req(1, 1'b0, BASE, 32'd0, 3'b011, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL func3_011_err got %b exp 1", e); end
        do_req(1, 1'b1, BASE, 32'h0000_0011, F_BU, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL store_unsigned_err got %b exp 1", e); end
        do_req(1, 1'b0, BASE, 32'd0, F_W, rd, e, lat);
        checks++;
        if (rd !== 32'h80AD_BEEF) begin errors++; $display("FAIL word_after_bad_store got %h exp 80adbeef", rd); end
    endtask

    task automatic test_half_store();
        logic [31:0] rd; logic e; int lat;
        do_req(1, 1'b1, BASE + 32'd2, 32'hCAFE_1234, F_H, rd, e, lat);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL sh_err got %b exp 0", e); end
        do_req(1, 1'b0, BASE, 32'd0, F_W, rd, e, lat);
        checks++;
        if (rd !== 32'h1234_BEEF) begin errors++; $display("FAIL lw_after_sh got %h exp 1234beef", rd); end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic e; int lat;
        do_req(0, 1'b1, BASE + 32'd8, 32'h55AA_00FF, F_W, rd, e, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL ws0_sw_latency got %0d exp 1", lat); end
        do_req(0, 1'b0, BASE + 32'd8, 32'd0, F_W, rd, e, lat);
        checks += 2;
        if (lat !== 1) begin errors++; $display("FAIL ws0_lw_latency got %0d exp 1", lat); end
        if (rd !== 32'h55AA_00FF) begin errors++; $display("FAIL ws0_lw got %h exp 55aa00ff", rd); end
        do_req(2, 1'b1, BASE, 32'h0BAD_F00D, F_W, rd, e, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL ws3_sw_latency got %0d exp 4", lat); end
        do_req(2, 1'b0, BASE, 32'd0, F_W, rd, e, lat);
        checks += 2;
        if (lat !== 4) begin errors++; $display("FAIL ws3_lw_latency got %0d exp 4", lat); end
        if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL ws3_lw got %h exp 0badf00d", rd); end
    endtask

    task automatic test_req_ignored();
        int n_ready;
        int first;
        @(negedge clk);
        we[2] = 1'b0; addr_v[2] = BASE; f3[2] = F_W; req[2] = 1'b1;
        @(posedge clk); #1;
        n_ready = 0;
        first   = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            req[2] = (i <= 3);
            @(posedge clk); #1;
            if (ready[2]) begin
                n_ready++;
                if (first == 0) first = i;
            end
        end
        checks += 2;
        if (n_ready !== 1) begin errors++; $display("FAIL pulses_in_wait got %0d responses exp 1", n_ready); end
        if (first !== 4) begin errors++; $display("FAIL pulses_latency got %0d exp 4", first); end

        @(negedge clk);
        req[2] = 1'b1;
        n_ready = 0;
        for (int i = 1; i <= 28; i++) begin
            @(posedge clk); #1;
            if (i == 20) req[2] = 1'b0;
            if (ready[2]) n_ready++;
        end
        checks++;
        if (n_ready !== 4) begin errors++; $display("FAIL req_held_high got %0d responses exp 4", n_ready); end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic e; int lat;
        int n_ready;
        @(negedge clk);
        we[2] = 1'b1; addr_v[2] = BASE; wdata[2] = 32'h1234_5678; f3[2] = F_W; req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        #1;
        checks += 3;
        if (ready[2] !== 1'b0) begin errors++; $display("FAIL rst_wait_ready got %b exp 0", ready[2]); end
        if (err[2] !== 1'b0) begin errors++; $display("FAIL rst_wait_err got %b exp 0", err[2]); end
        if (rdata[2] !== 32'd0) begin errors++; $display("FAIL rst_wait_rdata got %h exp 0", rdata[2]); end
        @(negedge clk);
        rst[2] = 1'b0;
        n_ready = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ready[2]) n_ready++;
        end
        checks++;
        if (n_ready !== 0) begin errors++; $display("FAIL rst_wait_no_resp got %0d responses exp 0", n_ready); end
        do_req(2, 1'b0, BASE, 32'd0, F_W, rd, e, lat);
        checks++;
        if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL store_dropped got %h exp 0badf00d", rd); end
    endtask

    task automatic test_reset_resp();
        logic [31:0] rd; logic e; int lat;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        we[2] = 1'b1; addr_v[2] = BASE; wdata[2] = 32'h600D_CAFE; f3[2] = F_W; req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (ready[2]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL rst_resp_ready got %b exp 1", seen); end
        rst[2] = 1'b1;
        #1;
        checks++;
        if (ready[2] !== 1'b0) begin errors++; $display("FAIL rst_resp_drop got %b exp 0", ready[2]); end
        @(negedge clk);
        rst[2] = 1'b0;
        do_req(2, 1'b0, BASE, 32'd0, F_W, rd, e, lat);
        checks++;
        if (rd !== 32'h600D_CAFE) begin errors++; $display("FAIL committed_write got %h exp 600dcafe", rd); end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; req[u] = 1'b0; we[u] = 1'b0;
            addr_v[u] = 32'd0; wdata[u] = 32'd0; f3[u] = 3'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_half_store();
        test_latency();
        test_req_ignored();
        test_reset_wait();
        test_reset_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
